mrdo_clk_en_gen: RTL and testbench
==================================

# mrdo_clk_en_gen

Reset sequencer and clock-enable generator for the Mr. Do core. It runs on the 98 MHz system clock from the PLL and consumes the PLL lock indication. It holds the core in reset until lock has been stable for a programmable interval. It then issues single-cycle enable strobes for the Z80 CPU (fractional divider, about 4.1 MHz) and the video pixel pipeline (integer divider, about 4.9 MHz), so the whole core stays in one clock domain.

## Interface
Parameters:
- LOCK_WAIT, default 1024: cycles of continuous synchronized lock required before release (1..65535).
- CPU_NUM, default 41: fractional CPU enable numerator. Constraint: 0 < CPU_NUM < CPU_DEN.
- CPU_DEN, default 980: fractional CPU enable denominator (≤ 65535); default gives 98 MHz × 41/980 = 4.1 MHz.
- PIX_DIV, default 20: integer pixel enable divisor (2..255); default gives 4.9 MHz.

Ports:
- clk_sys  in  1  98 MHz system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock, asynchronous to clk_sys; double-flop synchronized internally.
- pause  in  1  freezes CPU enable (present only with CLK_EN_PAUSE_EN).
- core_reset  out  1  registered reset to the rest of the core.
- ce_cpu  out  1  registered one-cycle CPU enable strobe.
- ce_pix  out  1  registered one-cycle pixel enable strobe.

## Operation
- Reset values: core_reset=1, ce_cpu=0, ce_pix=0, sync flops=0, state=WAIT_LOCK, lock counter=0, pix counter=0, CPU accumulator=0.
- State machine: WAIT_LOCK → COUNT → RUN.
  - WAIT_LOCK: advance to COUNT when the synchronized lock is 1.
  - COUNT: increment the lock counter each cycle the synchronized lock is 1. After LOCK_WAIT cycles, go to RUN and clear core_reset.
  - Any state: if the synchronized lock is 0, go to WAIT_LOCK, set core_reset=1, clear all counters and the accumulator, and force strobes to 0.
- Strobes are 0 in WAIT_LOCK and COUNT; strobes are generated in RUN only.
- Pixel enable: pix counter 0..PIX_DIV-1, wrapping. ce_pix=1 in the cycle the counter equals PIX_DIV-1.
- CPU enable: 16-bit accumulator, with a 17-bit sum.
  - Each RUN cycle: sum = acc + CPU_NUM.
  - If sum ≥ CPU_DEN: ce_cpu=1 and acc = sum − CPU_DEN; otherwise acc = sum.
  - Exactly CPU_NUM strobes per CPU_DEN cycles; never two in consecutive cycles while CPU_NUM·2 ≤ CPU_DEN.
- ce_cpu and ce_pix are independent and may coincide in the same cycle.

## Timing
- Number RUN cycles k=0,1,2… with k=0 the first cycle core_reset reads 0.
  - ce_pix is high at k ≡ PIX_DIV−1 (mod PIX_DIV).
  - ce_cpu is high at k iff floor((k+1)·CPU_NUM/CPU_DEN) > floor(k·CPU_NUM/CPU_DEN). With defaults, the first ce_cpu is at k=23.
- Lock rise to core_reset fall: 2 sync cycles + LOCK_WAIT cycles + 1 register cycle.
- Lock fall to core_reset rise: 3 clk_sys edges. The strobes go to 0 on the same edge.
- Lock glitch during COUNT (low for ≥ 1 synchronized cycle): the counter restarts from 0 and the full LOCK_WAIT interval is required again.
- reset asserted mid-RUN: on the next edge, core_reset=1, strobes=0, and everything returns to reset values, including the sync flops.
- The sync flops are reset, so lock must re-propagate after reset.

## Configuration
- CLK_EN_PAUSE_EN defined:
  - The pause port exists.
  - While pause=1 in RUN, ce_cpu=0 and the accumulator holds.
  - On release, the sequence continues from the held value; no strobe is lost or duplicated relative to unpaused cycles.
  - ce_pix and core_reset are unaffected.
- CLK_EN_PAUSE_EN undefined: no pause port; ce_cpu runs freely in RUN.

## Test plan
- Reset, then pll_locked=1 held: core_reset falls exactly 2+1024+1 cycles after lock is applied; ce_cpu/ce_pix stay 0 before that.
- RUN for 9800 cycles with defaults: exactly 410 ce_cpu and 490 ce_pix strobes; first ce_cpu at k=23, first ce_pix at k=19.
- Drop pll_locked mid-RUN: core_reset=1 and strobes=0 on the 3rd edge. Re-lock: the full LOCK_WAIT interval is repeated and k restarts at 0 (first ce_pix again at k=19).
- Lock pulse low for 1 cycle at COUNT=1000: no release at the original time; release 1027 cycles after the lock returns high.
- reset pulse during RUN: outputs return to reset values next edge and recover only after lock re-sync + LOCK_WAIT.
- CLK_EN_PAUSE_EN: pause for 500 cycles starting at k=100. ce_cpu count over 9800 unpaused RUN cycles is still 410; ce_pix count is unchanged (490 over 9800 cycles).

Source files
------------

// File: rtl/mrdo_clk_en_gen.sv
// mrdo_clk_en_gen: reset sequencer and single-domain clock-enable generator for the Mr. Do core.
// Latency: lock rise -> core_reset fall = 2 sync + LOCK_WAIT + 1 cycles; lock fall -> core_reset rise = 3 edges.
// Backpressure: none; strobes are free-running in RUN (ce_cpu frozen by pause when CLK_EN_PAUSE_EN is defined).
//
// Ports:
//   clk_sys    in   98 MHz system clock, the only clock
//   reset      in   synchronous active-high reset
//   pll_locked in   PLL lock, asynchronous; double-flop synchronized here
//   pause      in   freezes the CPU enable sequence (only with CLK_EN_PAUSE_EN)
//   core_reset out  registered reset for the rest of the core
//   ce_cpu     out  registered one-cycle CPU enable (fractional CPU_NUM/CPU_DEN)
//   ce_pix     out  registered one-cycle pixel enable (integer 1/PIX_DIV)
//
// Optional feature macro: CLK_EN_PAUSE_EN (adds the pause port).

module mrdo_clk_en_gen #(
  parameter int unsigned LOCK_WAIT = 1024,
  parameter int unsigned CPU_NUM   = 41,
  parameter int unsigned CPU_DEN   = 980,
  parameter int unsigned PIX_DIV   = 20
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
`ifdef CLK_EN_PAUSE_EN
  input  logic pause,
`endif
  output logic core_reset,
  output logic ce_cpu,
  output logic ce_pix
);

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_WAIT - 1);
  localparam logic [7:0]  PIX_LAST  = 8'(PIX_DIV - 1);
  localparam logic [15:0] NUM16     = 16'(CPU_NUM);
  localparam logic [15:0] DEN16     = 16'(CPU_DEN);
  localparam logic [16:0] NUM17     = {1'b0, NUM16};
  localparam logic [16:0] DEN17     = {1'b0, DEN16};

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_COUNT,
    ST_RUN
  } state_e;

  // Lock synchronizer
  logic sync1_q;
  logic sync2_q;
  logic lock_s;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign lock_s = sync2_q;

  // Sequencer / divider state
  state_e      state_q,      state_d;
  logic [15:0] lock_cnt_q,   lock_cnt_d;
  logic [7:0]  pix_cnt_q,    pix_cnt_d;
  logic [15:0] acc_q,        acc_d;
  logic        core_reset_q, core_reset_d;
  logic        ce_cpu_q,     ce_cpu_d;
  logic        ce_pix_q,     ce_pix_d;

  // Fractional step helpers; acc_q is always < CPU_DEN, so the 16-bit
  // subtraction of the wrapped case is exact modulo 2^16.
  logic [16:0] cpu_sum;
  logic        cpu_wrap;
  logic [15:0] acc_step;
  logic [7:0]  pix_next;

  always_comb begin
    cpu_sum  = {1'b0, acc_q} + NUM17;
    cpu_wrap = (cpu_sum >= DEN17);
    acc_step = cpu_wrap ? (cpu_sum[15:0] - DEN16) : cpu_sum[15:0];
    pix_next = (pix_cnt_q == PIX_LAST) ? 8'd0 : (pix_cnt_q + 8'd1);
  end

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    pix_cnt_d    = 8'd0;
    acc_d        = acc_q;
    core_reset_d = 1'b1;
    ce_cpu_d     = 1'b0;
    ce_pix_d     = 1'b0;

    unique case (state_q)
      ST_WAIT_LOCK: begin
        lock_cnt_d = 16'd0;
        acc_d      = 16'd0;
        if (lock_s) begin
          state_d = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (lock_cnt_q == LOCK_LAST) begin
          // Entering RUN: this edge starts cycle k=0. The registered
          // strobes describe the cycle being entered, so the accumulator
          // runs one step ahead: it holds the phase of cycle k+1 while
          // ce_cpu shows the decision for cycle k. Phase of k=0 is 0,
          // which never wraps because CPU_NUM < CPU_DEN.
          state_d      = ST_RUN;
          lock_cnt_d   = 16'd0;
          core_reset_d = 1'b0;
          pix_cnt_d    = 8'd0;
          acc_d        = NUM16;
          ce_cpu_d     = 1'b0;
          ce_pix_d     = 1'b0;
        end else begin
          lock_cnt_d = lock_cnt_q + 16'd1;
        end
      end

      ST_RUN: begin
        core_reset_d = 1'b0;
        pix_cnt_d    = pix_next;
        ce_pix_d     = (pix_next == PIX_LAST);
`ifdef CLK_EN_PAUSE_EN
        if (pause) begin
          // Hold the phase; the skipped cycle simply does not exist for
          // the CPU sequence, so nothing is lost or repeated.
          acc_d    = acc_q;
          ce_cpu_d = 1'b0;
        end else begin
          acc_d    = acc_step;
          ce_cpu_d = cpu_wrap;
        end
`else
        acc_d    = acc_step;
        ce_cpu_d = cpu_wrap;
`endif
      end

      default: begin
        state_d = ST_WAIT_LOCK;
      end
    endcase

    // Loss of lock overrides everything, from any state.
    if (!lock_s) begin
      state_d      = ST_WAIT_LOCK;
      lock_cnt_d   = 16'd0;
      pix_cnt_d    = 8'd0;
      acc_d        = 16'd0;
      core_reset_d = 1'b1;
      ce_cpu_d     = 1'b0;
      ce_pix_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_WAIT_LOCK;
      lock_cnt_q   <= 16'd0;
      pix_cnt_q    <= 8'd0;
      acc_q        <= 16'd0;
      core_reset_q <= 1'b1;
      ce_cpu_q     <= 1'b0;
      ce_pix_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      acc_q        <= acc_d;
      core_reset_q <= core_reset_d;
      ce_cpu_q     <= ce_cpu_d;
      ce_pix_q     <= ce_pix_d;
    end
  end

  assign core_reset = core_reset_q;
  assign ce_cpu     = ce_cpu_q;
  assign ce_pix     = ce_pix_q;

endmodule

// File: tb/tb_mrdo_clk_en_gen.sv
// tb_mrdo_clk_en_gen: directed bench for mrdo_clk_en_gen with default parameters.
// Latency: measures lock-to-release and unlock-to-reset edge counts against hand-derived values.
// Backpressure: n/a; pause window exercised when CLK_EN_PAUSE_EN is defined.

module tb_mrdo_clk_en_gen;

  logic clk_sys = 1'b0;
  logic reset;
  logic pll_locked;
`ifdef CLK_EN_PAUSE_EN
  logic pause;
`endif
  logic core_reset;
  logic ce_cpu;
  logic ce_pix;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_sys = ~clk_sys;

  mrdo_clk_en_gen dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pll_locked (pll_locked),
`ifdef CLK_EN_PAUSE_EN
    .pause      (pause),
`endif
    .core_reset (core_reset),
    .ce_cpu     (ce_cpu),
    .ce_pix     (ce_pix)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk_sys);
  endtask

  // Reference: strobe at CPU index m iff floor((m+1)*41/980) > floor(m*41/980).
  function automatic bit cpu_ref(input int m);
    return (((m + 1) * 41) / 980) > ((m * 41) / 980);
  endfunction

  // Counts edges from now until core_reset reads 0 (bounded), plus any
  // strobes seen while still in reset.
  task automatic wait_release(output int n, output int strobes);
    n = 0;
    strobes = 0;
    while (core_reset && n < 2000) begin
      tick();
      n++;
      if (core_reset && (ce_cpu || ce_pix)) strobes++;
    end
  endtask

  // Observes RUN cycles k=0..len-1 (caller is at the negedge of k=0).
  // With do_pause, pause is driven after sampling k=100..599, which
  // suppresses ce_cpu in cycles 101..600.
  task automatic run_window(input int len, input bit do_pause,
                            output int cpu_cnt, output int pix_cnt,
                            output int first_cpu, output int first_pix,
                            output int bad);
    bit e_cpu;
    bit e_pix;
    cpu_cnt = 0; pix_cnt = 0; first_cpu = -1; first_pix = -1; bad = 0;
    for (int k = 0; k < len; k++) begin
      if (do_pause && k > 100 && k <= 600) e_cpu = 1'b0;
      else e_cpu = cpu_ref((do_pause && k > 600) ? (k - 500) : k);
      e_pix = ((k % 20) == 19);
      if (ce_cpu !== e_cpu || ce_pix !== e_pix || core_reset !== 1'b0) bad++;
      if (ce_cpu) begin
        cpu_cnt++;
        if (first_cpu < 0) first_cpu = k;
      end
      if (ce_pix) begin
        if (k < 9800) pix_cnt++;
        if (first_pix < 0) first_pix = k;
      end
`ifdef CLK_EN_PAUSE_EN
      pause = (do_pause && k >= 100 && k <= 599);
`endif
      tick();
    end
`ifdef CLK_EN_PAUSE_EN
    pause = 1'b0;
`endif
  endtask

  int n, s, c_cpu, c_pix, f_cpu, f_pix, bad;

  initial begin
    reset      = 1'b1;
    pll_locked = 1'b0;
`ifdef CLK_EN_PAUSE_EN
    pause      = 1'b0;
`endif
    repeat (3) tick();
    check("reset_core_reset", core_reset, 1);
    check("reset_ce_cpu", ce_cpu, 0);
    check("reset_ce_pix", ce_pix, 0);

    reset = 1'b0;
    repeat (5) tick();
    check("nolock_core_reset", core_reset, 1);

    // First lock: 2 sync + 1024 + 1 register edges
    pll_locked = 1'b1;
    wait_release(n, s);
    check("lock_to_release", n, 1027);
    check("strobes_in_reset", s, 0);

    // Long RUN with defaults
    run_window(9800, 1'b0, c_cpu, c_pix, f_cpu, f_pix, bad);
    check("cpu_count_9800", c_cpu, 410);
    check("pix_count_9800", c_pix, 490);
    check("first_cpu_k", f_cpu, 23);
    check("first_pix_k", f_pix, 19);
    check("run_pattern_errs", bad, 0);

    // Lock drop timed so the 3rd edge lands on a would-be ce_pix (k=9819)
    repeat (16) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    check("unlock_edge2_core_reset", core_reset, 0);
    tick();
    check("unlock_edge3_core_reset", core_reset, 1);
    check("unlock_edge3_ce_pix", ce_pix, 0);
    check("unlock_edge3_ce_cpu", ce_cpu, 0);

    // Re-lock: full interval again, k restarts
    repeat (4) tick();
    pll_locked = 1'b1;
    wait_release(n, s);
    check("relock_to_release", n, 1027);
    check("relock_strobes_in_reset", s, 0);
    run_window(30, 1'b0, c_cpu, c_pix, f_cpu, f_pix, bad);
    check("relock_first_pix_k", f_pix, 19);
    check("relock_first_cpu_k", f_cpu, 23);
    check("relock_pattern_errs", bad, 0);

    // One-cycle lock glitch when the lock counter is at 1000
    pll_locked = 1'b0;
    repeat (5) tick();
    pll_locked = 1'b1;
    repeat (1003) tick();
    check("count_still_reset", core_reset, 1);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_release(n, s);
    check("glitch_return_to_release", n, 1027);

    // Reset pulse at k=18 (cycle 19 would have carried ce_pix)
    run_window(18, 1'b0, c_cpu, c_pix, f_cpu, f_pix, bad);
    check("pre_reset_pattern_errs", bad, 0);
    reset = 1'b1;
    tick();
    check("rst_pulse_core_reset", core_reset, 1);
    check("rst_pulse_ce_pix", ce_pix, 0);
    check("rst_pulse_ce_cpu", ce_cpu, 0);
    reset = 1'b0;
    wait_release(n, s);
    check("rst_to_release", n, 1027);

`ifdef CLK_EN_PAUSE_EN
    // 500 paused cycles inside 10300 RUN cycles -> 9800 unpaused
    run_window(10300, 1'b1, c_cpu, c_pix, f_cpu, f_pix, bad);
    check("pause_cpu_count", c_cpu, 410);
    check("pause_pix_count_9800", c_pix, 490);
    check("pause_pattern_errs", bad, 0);
`else
    run_window(100, 1'b0, c_cpu, c_pix, f_cpu, f_pix, bad);
    check("post_reset_first_pix_k", f_pix, 19);
    check("post_reset_cpu_count_100", c_cpu, 4);
    check("post_reset_pattern_errs", bad, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
